// File: rtl/cla_word_serial_adder_if.sv
// Request/result bundle for the word-serial adder: operands and start in,
// busy/done status and the assembled result out.
interface cla_word_serial_adder_if #(
  parameter int N     = 4,
  parameter int WORDS = 4
);
  localparam int W = N * WORDS;

  logic         start;
  logic         SUB;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic         Cin;
  logic         busy;
  logic         done;
  logic [W-1:0] S;
  logic         Cout;

  modport master (
    output start, SUB, A, B, Cin,
    input  busy, done, S, Cout
  );

  modport slave (
    input  start, SUB, A, B, Cin,
    output busy, done, S, Cout
  );
endinterface

// File: rtl/cla_word_serial_adder.sv
// Multi-precision add/sub through one shared N-bit CLA, one slice per clock, LSB first.
// Result after WORDS+1 edges from start; start is ignored while busy (no queuing).

module CarryLookaheadAdder #(
  parameter int N = 4
) (
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic         Cin,
  output logic [N-1:0] S,
  output logic         Cout
);
  logic [N-1:0] g;
  logic [N-1:0] p;
  logic [N:0]   c;
  logic         term;
  logic         prop;

  assign g = A & B;
  assign p = A ^ B;

  // Each carry is the flat sum-of-products of generates and the carry-in.
  always_comb begin
    c    = '0;
    term = 1'b0;
    prop = 1'b0;
    c[0] = Cin;
    for (int i = 0; i < N; i++) begin
      term = g[i];
      prop = p[i];
      for (int j = i - 1; j >= 0; j--) begin
        term = term | (prop & g[j]);
        prop = prop & p[j];
      end
      term     = term | (prop & Cin);
      c[i + 1] = term;
    end
  end

  assign S    = p ^ c[N-1:0];
  assign Cout = c[N];
endmodule

module cla_word_serial_adder #(
  parameter int N     = 4,
  parameter int WORDS = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  cla_word_serial_adder_if.slave    bus
);
  localparam int W  = N * WORDS;
  localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(WORDS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state;
  logic [W-1:0]  a_q;
  logic [W-1:0]  b_q;
  logic [W-1:0]  s_q;
  logic [IW-1:0] idx;
  logic          carry;
  logic          cout_q;
  logic          busy_q;
  logic          done_q;

  logic [N-1:0]  cla_a;
  logic [N-1:0]  cla_b;
  logic [N-1:0]  cla_s;
  logic          cla_cout;

  assign cla_a = a_q[idx*N +: N];
  assign cla_b = b_q[idx*N +: N];

  CarryLookaheadAdder #(.N(N)) u_cla (
    .A    (cla_a),
    .B    (cla_b),
    .Cin  (carry),
    .S    (cla_s),
    .Cout (cla_cout)
  );

  // B is stored pre-inverted for subtract, so RUN never needs the op code.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      a_q    <= '0;
      b_q    <= '0;
      s_q    <= '0;
      idx    <= '0;
      carry  <= 1'b0;
      cout_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            a_q    <= bus.A;
            b_q    <= bus.SUB ? ~bus.B : bus.B;
            carry  <= bus.SUB ? 1'b1 : bus.Cin;
            idx    <= '0;
            busy_q <= 1'b1;
            state  <= RUN;
          end else begin
            state  <= IDLE;
          end
        end
        RUN: begin
          s_q[idx*N +: N] <= cla_s;
          carry           <= cla_cout;
          if (idx == LAST_IDX) begin
            cout_q <= cla_cout;
            busy_q <= 1'b0;
            done_q <= 1'b1;
            idx    <= '0;
            state  <= DONE;
          end else begin
            idx    <= idx + IW'(1);
          end
        end
        default: begin
          busy_q <= 1'b0;
          done_q <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.S    = s_q;
  assign bus.Cout = cout_q;
endmodule

// File: tb/tb_cla_word_serial_adder.sv
// Bench for the word-serial adder: directed scenarios plus random operations
// checked against a plain-arithmetic model of {Cout,S}.
module tb_cla_word_serial_adder;
  localparam int N     = 4;
  localparam int WORDS = 4;
  localparam int W     = N * WORDS;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;

  cla_word_serial_adder_if #(.N(N), .WORDS(WORDS)) bus ();

  cla_word_serial_adder #(.N(N), .WORDS(WORDS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [W:0] ref_model(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic sub, input logic cin);
    logic [W-1:0] nb;
    nb = ~b;
    if (sub) return {1'b0, a} + {1'b0, nb} + (W+1)'(1);
    return {1'b0, a} + {1'b0, b} + (W+1)'(cin);
  endfunction

  // Holds start for one edge; afterwards the bench sits in the first busy cycle.
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub, input logic cin);
    bus.A     = a;
    bus.B     = b;
    bus.SUB   = sub;
    bus.Cin   = cin;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    while (!bus.done && lat < 20) begin
      tick();
      lat++;
    end
    if (!bus.done) lat = -1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    n_tests++;
    if ({bus.busy, bus.done, bus.Cout} !== 3'b000 || bus.S !== '0) begin
      n_fail++;
      $display("FAIL reset_hold: busy=%b done=%b Cout=%b S=%h, want 0 0 0 0000",
               bus.busy, bus.done, bus.Cout, bus.S);
    end
    rst = 1'b0;
    tick();
    n_tests++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_idle: busy=%b done=%b, want 0 0", bus.busy, bus.done);
    end
  endtask

  task automatic test_basic_add();
    logic [W:0] exp;
    exp = ref_model(16'h1234, 16'h4321, 1'b0, 1'b0);
    issue(16'h1234, 16'h4321, 1'b0, 1'b0);
    for (int c = 1; c <= WORDS; c++) begin
      n_tests++;
      if (bus.busy !== 1'b1 || bus.done !== 1'b0) begin
        n_fail++;
        $display("FAIL basic_busy cycle %0d: busy=%b done=%b, want 1 0", c, bus.busy, bus.done);
      end
      tick();
    end
    n_tests++;
    if (bus.done !== 1'b1 || bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_done_cycle: busy=%b done=%b, want 0 1", bus.busy, bus.done);
    end
    n_tests++;
    if ({bus.Cout, bus.S} !== exp || bus.S !== 16'h5555) begin
      n_fail++;
      $display("FAIL basic_result: got %b_%h, want %b_%h", bus.Cout, bus.S, exp[W], exp[W-1:0]);
    end
    tick();
    n_tests++;
    if (bus.done !== 1'b0 || bus.S !== 16'h5555) begin
      n_fail++;
      $display("FAIL basic_pulse_hold: done=%b S=%h, want 0 5555", bus.done, bus.S);
    end
  endtask

  task automatic test_carry_chain();
    logic [W-1:0] bs [2] = '{16'h0001, 16'h0000};
    logic         cs [2] = '{1'b0, 1'b1};
    int lat;
    for (int k = 0; k < 2; k++) begin
      issue(16'hFFFF, bs[k], 1'b0, cs[k]);
      wait_done(lat);
      n_tests++;
      if (lat != WORDS || {bus.Cout, bus.S} !== 17'h10000) begin
        n_fail++;
        $display("FAIL carry_chain[%0d]: lat=%0d Cout=%b S=%h, want lat=%0d 1 0000",
                 k, lat, bus.Cout, bus.S, WORDS);
      end
      tick();
    end
  endtask

  task automatic test_subtract();
    logic [W-1:0] as [2] = '{16'h0005, 16'h0007};
    logic [W-1:0] bs [2] = '{16'h0007, 16'h0005};
    logic [W:0]   exp;
    int lat;
    for (int k = 0; k < 2; k++) begin
      exp = ref_model(as[k], bs[k], 1'b1, 1'b0);
      issue(as[k], bs[k], 1'b1, 1'b0);
      wait_done(lat);
      n_tests++;
      if (lat != WORDS || {bus.Cout, bus.S} !== exp) begin
        n_fail++;
        $display("FAIL subtract[%0d]: lat=%0d got %b_%h, want %b_%h",
                 k, lat, bus.Cout, bus.S, exp[W], exp[W-1:0]);
      end
      tick();
    end
  endtask

  task automatic test_start_while_busy();
    int lat;
    int extra = 0;
    issue(16'h0001, 16'h0001, 1'b0, 1'b0);
    tick();
    bus.A     = 16'hAAAA;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    wait_done(lat);
    n_tests++;
    if (lat < 0 || bus.S !== 16'h0002 || bus.Cout !== 1'b0) begin
      n_fail++;
      $display("FAIL busy_start_result: lat=%0d S=%h Cout=%b, want 0002 0", lat, bus.S, bus.Cout);
    end
    for (int c = 0; c < 12; c++) begin
      tick();
      if (bus.done || bus.busy) extra++;
    end
    n_tests++;
    if (extra != 0) begin
      n_fail++;
      $display("FAIL busy_start_ignored: %0d extra busy/done cycles, want 0", extra);
    end
  endtask

  task automatic test_reset_midop();
    int seen = 0;
    issue(16'hFFFF, 16'hFFFF, 1'b0, 1'b0);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_tests++;
    if ({bus.busy, bus.done, bus.Cout} !== 3'b000 || bus.S !== '0) begin
      n_fail++;
      $display("FAIL reset_midop: busy=%b done=%b Cout=%b S=%h, want 0 0 0 0000",
               bus.busy, bus.done, bus.Cout, bus.S);
    end
    for (int c = 0; c < 10; c++) begin
      tick();
      if (bus.done) seen++;
    end
    n_tests++;
    if (seen != 0) begin
      n_fail++;
      $display("FAIL reset_midop_no_done: %0d done pulses, want 0", seen);
    end
  endtask

  task automatic test_back_to_back();
    logic [W:0] exp;
    int lat;
    issue(16'h1111, 16'h2222, 1'b0, 1'b0);
    wait_done(lat);
    exp = ref_model(16'h0F0F, 16'h00F1, 1'b0, 1'b0);
    issue(16'h0F0F, 16'h00F1, 1'b0, 1'b0);
    n_tests++;
    if (bus.busy !== 1'b1 || bus.done !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_accept: busy=%b done=%b, want 1 0", bus.busy, bus.done);
    end
    wait_done(lat);
    n_tests++;
    if (lat != WORDS || {bus.Cout, bus.S} !== exp) begin
      n_fail++;
      $display("FAIL b2b_result: lat=%0d got %b_%h, want lat=%0d %b_%h",
               lat, bus.Cout, bus.S, WORDS, exp[W], exp[W-1:0]);
    end
    tick();
  endtask

  // Inputs are scrambled while busy to confirm the operands were latched.
  task automatic test_random();
    logic [W-1:0] a, b;
    logic         sub, cin;
    logic [W:0]   exp;
    int lat;
    for (int k = 0; k < 40; k++) begin
      a   = W'($urandom);
      b   = W'($urandom);
      sub = 1'($urandom);
      cin = 1'($urandom);
      exp = ref_model(a, b, sub, cin);
      issue(a, b, sub, cin);
      lat = 0;
      while (!bus.done && lat < 20) begin
        bus.A   = W'($urandom);
        bus.B   = W'($urandom);
        bus.SUB = 1'($urandom);
        bus.Cin = 1'($urandom);
        tick();
        lat++;
      end
      n_tests++;
      if (!bus.done || lat != WORDS || {bus.Cout, bus.S} !== exp) begin
        n_fail++;
        $display("FAIL random[%0d]: a=%h b=%h sub=%b cin=%b lat=%0d got %b_%h, want %b_%h",
                 k, a, b, sub, cin, lat, bus.Cout, bus.S, exp[W], exp[W-1:0]);
      end
      if ($urandom_range(0, 1) == 0) tick();
    end
    tick();
  endtask

  initial begin
    bus.start = 1'b0;
    bus.SUB   = 1'b0;
    bus.A     = '0;
    bus.B     = '0;
    bus.Cin   = 1'b0;
    test_reset();
    test_basic_add();
    test_carry_chain();
    test_subtract();
    test_start_while_busy();
    test_reset_midop();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/cla_word_serial_adder.md
Name: cla_word_serial_adder

Overview:
- Multi-precision add/subtract sequencer around one shared N-bit CarryLookaheadAdder instance (ports A, B, Cin, S, Cout).
- Latches two WORDS*N-bit operands, then feeds the CLA one N-bit slice per clock, LSB slice first.
- Chains the carry through a register and assembles the full result.
- Lets wide arithmetic reuse the team's small CLA instead of instantiating a wide one.

Parameters:
- N, 4, width of the shared CLA slice in bits.
- WORDS, 4, number of slices per operand; operand width W = N*WORDS.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only when busy=0.
- SUB  input  1  0 = add, 1 = subtract (A - B); latched with start.
- A  input  W  operand A; latched with start.
- B  input  W  operand B; latched with start.
- Cin  input  1  carry-in for add; ignored when SUB=1.
- busy  output  1  operation in progress.
- done  output  1  one-cycle pulse: result valid.
- S  output  W  result; held until the next accepted start.
- Cout  output  1  final carry-out. For SUB: 1 = no borrow.

Behaviour:
- Reset: state=IDLE; busy=0, done=0, S=0, Cout=0, slice index=0, carry reg=0. Applies in any state, including mid-operation; the partial result is discarded.
- FSM states IDLE, RUN, DONE.
  - IDLE: start=1 at edge k latches A, B and SUB. Carry reg gets Cin when SUB=0, 1 when SUB=1. Index=0, state goes to RUN, busy=1 after edge k. start=0 stays in IDLE.
  - RUN: CLA inputs are A slice[idx], B' slice[idx], and carry reg.
    - B' = B when SUB=0, ~B when SUB=1.
    - Each edge writes the CLA S into S slice[idx] and the CLA Cout into carry reg, then increments idx.
    - On the edge processing idx=WORDS-1: Cout gets the CLA Cout, state goes to DONE, busy goes 0, done goes 1.
    - Slices therefore complete at edges k+1..k+WORDS.
  - DONE: done=1 for exactly one cycle, then IDLE. start=1 in DONE is accepted as in IDLE (back-to-back), giving done=0 and busy=1 on the next cycle.
- start while busy=1 is ignored. A, B, SUB and Cin changes while busy do not affect the result.
- S slices not yet written hold the previous result during RUN. S and Cout are valid only from the done pulse onward.
- Latency: start edge to done high = WORDS+1 edges. Throughput: one operation per WORDS+1 cycles.
- Arithmetic is modulo 2^W. Result is {Cout,S} = A + B + Cin (add) or A + ~B + 1 (sub).
- WORDS=1 is legal: a single RUN cycle.

Test Plan (N=4, WORDS=4):
- Basic add: A=16'h1234, B=16'h4321, Cin=0, start at cycle 0. Required: busy=1 for cycles 1-4, done=1 in cycle 5, S=16'h5555, Cout=0.
- Full carry chain: A=16'hFFFF, B=16'h0001, Cin=0. Required: S=16'h0000, Cout=1. Repeat with B=0, Cin=1: same result.
- Subtract: SUB=1, A=16'h0005, B=16'h0007. Required: S=16'hFFFE, Cout=0. Then A=16'h0007, B=16'h0005: S=16'h0002, Cout=1.
- Start while busy: start A=16'h0001, B=16'h0001. Two cycles later pulse start with A=16'hAAAA. Required: single done pulse, S=16'h0002; the second start is ignored.
- Reset mid-op: start A=16'hFFFF, B=16'hFFFF, assert rst during cycle 2. Required: next cycle busy=0, done=0, S=0, Cout=0, and no done pulse follows.
- Back-to-back: assert start during the done cycle with A=16'h0F0F, B=16'h00F1. Required: busy=1 next cycle, done 5 cycles later, S=16'h1000, Cout=0.
